// File: rtl/load_cell_a2d.sv
// load_cell_a2d
//   Samples the left load cell, the right load cell and the battery divider from an
//   8-channel SPI A2D, one channel per conversion in round-robin order. Each result
//   is held in its own 12-bit register. The SPI master is built in: SCLK idles high,
//   frames are 16 bits, MSB first.
//   A conversion is two frames separated by a 2-clk gap. Both frames send the same
//   channel command. The first frame's read data is discarded, because the A2D
//   returns the channel addressed in the previous frame.
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   nxt              start a conversion of the next channel (ignored while busy)
//   MISO             A2D serial data out
//   SS_n/SCLK/MOSI   SPI chip select (active low), clock, command data
//   lft_ld/rght_ld   latest load-cell readings, 12-bit unsigned
//   batt             latest battery reading, 12-bit unsigned
//   busy             conversion in progress
//   done             1-clk pulse in the cycle a result register takes its new value
module load_cell_a2d #(
  parameter int unsigned SCLK_DIV = 16,
  parameter logic [2:0]  LFT_CH   = 3'd0,
  parameter logic [2:0]  RGHT_CH  = 3'd4,
  parameter logic [2:0]  BATT_CH  = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HALF    = SCLK_DIV / 2;
  localparam int unsigned FRM_LEN = 17 * SCLK_DIV;
  localparam int unsigned CW      = $clog2(FRM_LEN + 1);
  localparam int unsigned DW      = $clog2(SCLK_DIV);

  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_BEND = CW'(HALF + 16 * SCLK_DIV);
  localparam logic [CW-1:0] C_LEN  = CW'(FRM_LEN);
  localparam logic [DW-1:0] K_RISE = DW'(HALF);

  typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;       // 0 = left, 1 = right, 2 = battery
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [11:0]   shift_q, shift_d;   // 16 bits shift through; only the low 12 survive
  logic [11:0]   lft_q, lft_d;
  logic [11:0]   rght_q, rght_d;
  logic [11:0]   batt_q, batt_d;

  logic [2:0]    cur_ch;
  logic [15:0]   cmd;
  logic [CW-1:0] k;                  // clocks since the end of the front porch
  logic [3:0]    bit_idx;
  logic          in_bits;

  assign cur_ch  = (ptr_q == 2'd0) ? LFT_CH : (ptr_q == 2'd1) ? RGHT_CH : BATT_CH;
  assign cmd     = {2'b00, cur_ch, 11'h000};
  assign k       = cnt_q - C_HALF;
  assign bit_idx = k[DW+3:DW];
  assign in_bits = (cnt_q >= C_HALF) && (cnt_q < C_BEND);

  // All outputs are registered. The value computed for frame count c is visible
  // from the next edge on. This makes done land 34*D+3 clks after nxt is sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    batt_d  = batt_q;
    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        if (nxt) begin
          state_d = FRM1;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FRM1, FRM2: begin
        if (cnt_q == C_LEN) begin
          // Only FRM2 reaches this count. It is the cycle that raises SS_n and publishes the result.
          ss_n_d  = 1'b1;
          sclk_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          case (ptr_q)
            2'd0:    lft_d  = shift_q;
            2'd1:    rght_d = shift_q;
            default: batt_d = shift_q;
          endcase
          ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        end else begin
          ss_n_d = 1'b0;
          sclk_d = 1'b1;
          if (in_bits) begin
            // First half of each SCLK period is low: the top bit of the phase gives the level.
            sclk_d = k[DW-1];
            if (k[DW-1:0] == '0)
              mosi_d = cmd[4'd15 - bit_idx];
            if ((state_q == FRM2) && (k[DW-1:0] == K_RISE))
              shift_d = {shift_q[10:0], MISO};
          end
          cnt_d = cnt_q + 1'b1;
          if ((state_q == FRM1) && (cnt_q == C_LEN - 1'b1)) begin
            state_d = GAP;
            cnt_d   = '0;
          end
        end
      end
      GAP: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FRM2;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      batt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      batt_q  <= batt_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign lft_ld  = lft_q;
  assign rght_ld = rght_q;
  assign batt    = batt_q;

endmodule
